// File: rtl/bp_be_late_wb_arbiter.sv
// Late writeback arbiter: merges long-unit and late-load completions onto
// one integer and one fp writeback port per cycle, tracks pending writes.
// Ports: clk_i/reset_i (sync, active-high); score_v_i counts a dispatched
// late-writeback instruction; long_*/mem_* are valid/ready-and completion
// requesters (ird_w/frd_w select file); iwb_*/fwb_* are registered write
// packets; fflags_v_o/fflags_o carry OR of granted flags; busy_o when any
// scored late write has not yet retired.
// Config: define BP_BE_LATE_WB_RR_EN for round-robin conflict resolution,
// otherwise the late-load (mem) requester always wins a conflict.
module bp_be_late_wb_arbiter #(
   parameter int reg_addr_width_p = 5,
   parameter int data_width_p     = 64,
   parameter int pending_els_p    = 8
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        score_v_i,

   input  logic                        long_v_i,
   output logic                        long_ready_and_o,
   input  logic                        long_ird_w_i,
   input  logic                        long_frd_w_i,
   input  logic [reg_addr_width_p-1:0] long_rd_addr_i,
   input  logic [data_width_p-1:0]     long_data_i,
   input  logic [4:0]                  long_fflags_i,

   input  logic                        mem_v_i,
   output logic                        mem_ready_and_o,
   input  logic                        mem_ird_w_i,
   input  logic                        mem_frd_w_i,
   input  logic [reg_addr_width_p-1:0] mem_rd_addr_i,
   input  logic [data_width_p-1:0]     mem_data_i,
   input  logic [4:0]                  mem_fflags_i,

   output logic                        iwb_v_o,
   output logic [reg_addr_width_p-1:0] iwb_rd_addr_o,
   output logic [data_width_p-1:0]     iwb_data_o,
   output logic                        fwb_v_o,
   output logic [reg_addr_width_p-1:0] fwb_rd_addr_o,
   output logic [data_width_p-1:0]     fwb_data_o,
   output logic                        fflags_v_o,
   output logic [4:0]                  fflags_o,
   output logic                        busy_o
);

   localparam int cnt_w_lp = $clog2(pending_els_p + 1);

   logic long_int, long_fp, mem_int, mem_fp;
   logic conflict, mem_wins;
   logic long_gnt, mem_gnt;

   logic                        iwb_v_q, iwb_v_d;
   logic [reg_addr_width_p-1:0] iwb_addr_q, iwb_addr_d;
   logic [data_width_p-1:0]     iwb_data_q, iwb_data_d;
   logic                        fwb_v_q, fwb_v_d;
   logic [reg_addr_width_p-1:0] fwb_addr_q, fwb_addr_d;
   logic [data_width_p-1:0]     fwb_data_q, fwb_data_d;
   logic                        fflags_v_q, fflags_v_d;
   logic [4:0]                  fflags_q, fflags_d;
   logic [cnt_w_lp-1:0]         pending_q, pending_d;
   logic                        busy_q, busy_d;

   assign long_int = long_v_i & long_ird_w_i;
   assign long_fp  = long_v_i & long_frd_w_i;
   assign mem_int  = mem_v_i & mem_ird_w_i;
   assign mem_fp   = mem_v_i & mem_frd_w_i;

   // Only a shared destination file causes contention.
   assign conflict = (long_int & mem_int) | (long_fp & mem_fp);

`ifdef BP_BE_LATE_WB_RR_EN
   // last_q: 0 = long won the last conflict, 1 = mem did.
   logic last_q, last_d;

   assign mem_wins = ~last_q;

   always_comb begin
      last_d = last_q;
      if (conflict) last_d = mem_wins;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) last_q <= 1'b0;
      else         last_q <= last_d;
   end
`else
   assign mem_wins = 1'b1;
`endif

   // Grants depend only on the two valids, never on a requester's ready.
   assign long_gnt = long_v_i & ~reset_i & ~(conflict & mem_wins);
   assign mem_gnt  = mem_v_i & ~reset_i & ~(conflict & ~mem_wins);

   assign long_ready_and_o = long_gnt;
   assign mem_ready_and_o  = mem_gnt;

   always_comb begin
      iwb_v_d    = 1'b0;
      iwb_addr_d = iwb_addr_q;
      iwb_data_d = iwb_data_q;
      if (long_gnt & long_ird_w_i) begin
         iwb_v_d    = 1'b1;
         iwb_addr_d = long_rd_addr_i;
         iwb_data_d = long_data_i;
      end else if (mem_gnt & mem_ird_w_i) begin
         iwb_v_d    = 1'b1;
         iwb_addr_d = mem_rd_addr_i;
         iwb_data_d = mem_data_i;
      end

      fwb_v_d    = 1'b0;
      fwb_addr_d = fwb_addr_q;
      fwb_data_d = fwb_data_q;
      if (long_gnt & long_frd_w_i) begin
         fwb_v_d    = 1'b1;
         fwb_addr_d = long_rd_addr_i;
         fwb_data_d = long_data_i;
      end else if (mem_gnt & mem_frd_w_i) begin
         fwb_v_d    = 1'b1;
         fwb_addr_d = mem_rd_addr_i;
         fwb_data_d = mem_data_i;
      end

      fflags_v_d = long_gnt | mem_gnt;
      fflags_d   = fflags_q;
      if (fflags_v_d)
         fflags_d = (long_gnt ? long_fflags_i : 5'b0)
                  | (mem_gnt ? mem_fflags_i : 5'b0);

      // Retire exactly when the write packet is visible on the outputs.
      pending_d = pending_q + cnt_w_lp'(score_v_i)
                - cnt_w_lp'(iwb_v_q) - cnt_w_lp'(fwb_v_q);
      busy_d    = (pending_d != '0);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         iwb_v_q    <= 1'b0;
         fwb_v_q    <= 1'b0;
         fflags_v_q <= 1'b0;
         fflags_q   <= 5'b0;
         pending_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         iwb_v_q    <= iwb_v_d;
         fwb_v_q    <= fwb_v_d;
         fflags_v_q <= fflags_v_d;
         fflags_q   <= fflags_d;
         pending_q  <= pending_d;
         busy_q     <= busy_d;
      end
   end

   always_ff @(posedge clk_i) begin
      iwb_addr_q <= iwb_addr_d;
      iwb_data_q <= iwb_data_d;
      fwb_addr_q <= fwb_addr_d;
      fwb_data_q <= fwb_data_d;
   end

   assign iwb_v_o       = iwb_v_q;
   assign iwb_rd_addr_o = iwb_addr_q;
   assign iwb_data_o    = iwb_data_q;
   assign fwb_v_o       = fwb_v_q;
   assign fwb_rd_addr_o = fwb_addr_q;
   assign fwb_data_o    = fwb_data_q;
   assign fflags_v_o    = fflags_v_q;
   assign fflags_o      = fflags_q;
   assign busy_o        = busy_q;

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
      !(score_v_i && pending_q == cnt_w_lp'(pending_els_p)));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
      (32'(pending_q) + 32'(score_v_i)) >= (32'(iwb_v_q) + 32'(fwb_v_q)));
   a_long_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
      long_v_i |-> (long_ird_w_i ^ long_frd_w_i));
   a_mem_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
      mem_v_i |-> (mem_ird_w_i ^ mem_frd_w_i));
`endif

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Bench for bp_be_late_wb_arbiter: directed scenarios then random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_bp_be_late_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        score_v_i = 1'b0;
   logic        long_v_i = 1'b0, long_ird_w_i = 1'b0, long_frd_w_i = 1'b0;
   logic [4:0]  long_rd_addr_i = '0, long_fflags_i = '0;
   logic [63:0] long_data_i = '0;
   logic        mem_v_i = 1'b0, mem_ird_w_i = 1'b0, mem_frd_w_i = 1'b0;
   logic [4:0]  mem_rd_addr_i = '0, mem_fflags_i = '0;
   logic [63:0] mem_data_i = '0;
   logic        long_ready_and_o, mem_ready_and_o;
   logic        iwb_v_o, fwb_v_o, fflags_v_o, busy_o;
   logic [4:0]  iwb_rd_addr_o, fwb_rd_addr_o, fflags_o;
   logic [63:0] iwb_data_o, fwb_data_o;

   always #5 clk = ~clk;

   bp_be_late_wb_arbiter dut (
      .clk_i(clk), .reset_i(reset_i), .score_v_i(score_v_i),
      .long_v_i(long_v_i), .long_ready_and_o(long_ready_and_o),
      .long_ird_w_i(long_ird_w_i), .long_frd_w_i(long_frd_w_i),
      .long_rd_addr_i(long_rd_addr_i), .long_data_i(long_data_i),
      .long_fflags_i(long_fflags_i),
      .mem_v_i(mem_v_i), .mem_ready_and_o(mem_ready_and_o),
      .mem_ird_w_i(mem_ird_w_i), .mem_frd_w_i(mem_frd_w_i),
      .mem_rd_addr_i(mem_rd_addr_i), .mem_data_i(mem_data_i),
      .mem_fflags_i(mem_fflags_i),
      .iwb_v_o(iwb_v_o), .iwb_rd_addr_o(iwb_rd_addr_o),
      .iwb_data_o(iwb_data_o),
      .fwb_v_o(fwb_v_o), .fwb_rd_addr_o(fwb_rd_addr_o),
      .fwb_data_o(fwb_data_o),
      .fflags_v_o(fflags_v_o), .fflags_o(fflags_o), .busy_o(busy_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model state: pending count, conflicts seen since reset, expected outputs.
   int          pend_m = 0;
   int          conf_cnt = 0;
   logic        lg = 1'b0, mg = 1'b0;
   logic        e_iv = 1'b0, e_fv = 1'b0, e_xv = 1'b0;
   logic [4:0]  e_ia = '0, e_fa = '0, e_xf = '0;
   logic [63:0] e_id = '0, e_fd = '0;

   task automatic step(input logic sc,
                       input logic lv, input logic li, input logic [4:0] la,
                       input logic [63:0] ld, input logic [4:0] lf,
                       input logic mv, input logic mi, input logic [4:0] ma,
                       input logic [63:0] md, input logic [4:0] mf);
      logic conf, mwin;
      logic n_iv, n_fv, n_xv;
      logic [4:0] n_ia, n_fa, n_xf;
      logic [63:0] n_id, n_fd;
      score_v_i = sc;
      long_v_i = lv; long_ird_w_i = li; long_frd_w_i = ~li;
      long_rd_addr_i = la; long_data_i = ld; long_fflags_i = lf;
      mem_v_i = mv; mem_ird_w_i = mi; mem_frd_w_i = ~mi;
      mem_rd_addr_i = ma; mem_data_i = md; mem_fflags_i = mf;
      #1;
      conf = lv && mv && (li == mi);
`ifdef BP_BE_LATE_WB_RR_EN
      mwin = (conf_cnt % 2 == 0);
`else
      mwin = 1'b1;
`endif
      lg = lv && !(conf && mwin);
      mg = mv && !(conf && !mwin);
      if (conf) conf_cnt++;
      chk("long_ready", long_ready_and_o, lg);
      chk("mem_ready", mem_ready_and_o, mg);
      n_iv = (lg && li) || (mg && mi);
      n_ia = (lg && li) ? la : ma;
      n_id = (lg && li) ? ld : md;
      n_fv = (lg && !li) || (mg && !mi);
      n_fa = (lg && !li) ? la : ma;
      n_fd = (lg && !li) ? ld : md;
      n_xv = lg || mg;
      n_xf = (lg ? lf : 5'd0) | (mg ? mf : 5'd0);
      @(posedge clk); #1;
      pend_m = pend_m + int'(sc) - int'(e_iv) - int'(e_fv);
      e_iv = n_iv; e_ia = n_ia; e_id = n_id;
      e_fv = n_fv; e_fa = n_fa; e_fd = n_fd;
      e_xv = n_xv; e_xf = n_xf;
      chk("iwb_v", iwb_v_o, e_iv);
      if (e_iv) begin
         chk("iwb_addr", iwb_rd_addr_o, e_ia);
         chk("iwb_data", iwb_data_o, e_id);
      end
      chk("fwb_v", fwb_v_o, e_fv);
      if (e_fv) begin
         chk("fwb_addr", fwb_rd_addr_o, e_fa);
         chk("fwb_data", fwb_data_o, e_fd);
      end
      chk("fflags_v", fflags_v_o, e_xv);
      if (e_xv) chk("fflags", fflags_o, e_xf);
      chk("busy", busy_o, pend_m != 0);
   endtask

   task automatic idle(input logic sc);
      step(sc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset_i = 1'b1; score_v_i = 1'b0;
      long_v_i = 1'b1; long_ird_w_i = 1'b1; long_frd_w_i = 1'b0;
      mem_v_i = 1'b1; mem_ird_w_i = 1'b1; mem_frd_w_i = 1'b0;
      #1;
      chk("rst_long_ready", long_ready_and_o, 0);
      chk("rst_mem_ready", mem_ready_and_o, 0);
      @(posedge clk); #1;
      reset_i = 1'b0; long_v_i = 1'b0; mem_v_i = 1'b0;
      chk("rst_iwb_v", iwb_v_o, 0);
      chk("rst_fwb_v", fwb_v_o, 0);
      chk("rst_fflags_v", fflags_v_o, 0);
      chk("rst_fflags", fflags_o, 0);
      chk("rst_busy", busy_o, 0);
      pend_m = 0; conf_cnt = 0; lg = 0; mg = 0;
      e_iv = 0; e_fv = 0; e_xv = 0;
   endtask

   logic        rl_v, rl_i, rm_v, rm_i, sc;
   logic [4:0]  rl_a, rl_f, rm_a, rm_f;
   logic [63:0] rl_d, rm_d;
   int          avail;

   initial begin
      @(posedge clk); #1;
      do_reset();
      idle(0); idle(0);

      // Two scores, then long->int and mem->fp together.
      idle(1); idle(1);
      step(0, 1, 1, 5'd5, 64'hA, 0, 1, 0, 5'd3, 64'hB, 0);
      idle(0); idle(0);

      // Persistent int conflict for three cycles.
      do_reset();
      repeat (4) idle(1);
      repeat (3) step(0, 1, 1, 5'd7, 64'h70, 0, 1, 1, 5'd9, 64'h90, 0);
      idle(0); idle(0);

      // fflags merging.
      do_reset();
      repeat (4) idle(1);
      step(0, 1, 0, 5'd1, 64'h11, 5'h01, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 5'd2, 64'h22, 5'h10);
      step(0, 1, 1, 5'd3, 64'h33, 5'h04, 1, 0, 5'd4, 64'h44, 5'h02);
      idle(0); idle(0);

      // Score coinciding with two retirements while pending is 1.
      do_reset();
      idle(1);
      step(0, 1, 1, 5'd6, 64'h66, 0, 1, 0, 5'd8, 64'h88, 0);
      idle(1);
      idle(0);

      // Reset mid-operation, then conflict arbitration restarts.
      repeat (3) idle(1);
      step(0, 1, 1, 5'd10, 64'hAA, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_iwb_v", iwb_v_o, 1);
      do_reset();
      idle(1); idle(1);
      step(0, 1, 0, 5'd11, 64'hB1, 0, 1, 0, 5'd12, 64'hC1, 0);
      chk("rr_restart_mem", mem_ready_and_o, 1);
      idle(0); idle(0);

      // Random traffic.
      do_reset();
      rl_v = 0; rm_v = 0; avail = 0;
      rl_i = 0; rm_i = 0; rl_a = 0; rm_a = 0;
      rl_d = 0; rm_d = 0; rl_f = 0; rm_f = 0;
      for (int n = 0; n < 500; n++) begin
         if (rl_v && lg) rl_v = 0;
         if (rm_v && mg) rm_v = 0;
         if (!rl_v && avail > 0 && $urandom_range(0, 2) != 0) begin
            rl_v = 1; rl_i = 1'($urandom_range(0, 1));
            rl_a = 5'($urandom); rl_f = 5'($urandom);
            rl_d = {$urandom, $urandom}; avail--;
         end
         if (!rm_v && avail > 0 && $urandom_range(0, 2) != 0) begin
            rm_v = 1; rm_i = 1'($urandom_range(0, 1));
            rm_a = 5'($urandom); rm_f = 5'($urandom);
            rm_d = {$urandom, $urandom}; avail--;
         end
         sc = (pend_m < 8) && ($urandom_range(0, 1) == 1);
         step(sc, rl_v, rl_i, rl_a, rl_d, rl_f,
              rm_v, rm_i, rm_a, rm_d, rm_f);
         if (sc) avail++;
      end
      idle(0); idle(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
